// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: req/ack fetch port, small instruction FIFO, redirect squash.
// Optional FETCH_SEQ_PERF_EN builds saturating fetch/squash counters; otherwise both read 0.
module fetch_sequencer #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH      = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PCResult,
  output logic [31:0] Address,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemAck,
  input  logic [31:0] MemData,
  output logic        InstrValid,
  output logic [31:0] Instruction,
  output logic [31:0] InstrPC,
  input  logic        InstrReady,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic [31:0] FetchCount,
  output logic [31:0] SquashCount
);

  localparam int unsigned PW = (DEPTH > 2) ? 2 : 1;
  localparam int unsigned CW = (DEPTH > 3) ? 3 : 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  localparam logic [0:0] FETCH  = 1'b0;
  localparam logic [0:0] SQUASH = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [31:0]   hold_q, hold_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   pc_mem_q  [DEPTH];
  logic [31:0]   pc_mem_d  [DEPTH];
  logic [31:0]   ins_mem_q [DEPTH];
  logic [31:0]   ins_mem_d [DEPTH];

  logic room, valid, pop, in_fetch, req, ack, push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    room     = cnt_q < DEPTH_C;
    valid    = cnt_q != '0;
    pop      = valid && InstrReady;
    in_fetch = state_q == FETCH;
    req      = in_fetch ? room : 1'b1;
    ack      = MemAck && req;
    push     = in_fetch && ack && !Redirect;

    // A redirect only needs a squash when a fetch is outstanding and not acked this cycle.
    state_d = state_q;
    hold_d  = hold_q;
    if (in_fetch) begin
      if (Redirect && req && !MemAck) begin
        state_d = SQUASH;
        hold_d  = PCResult;
      end
    end else if (MemAck) begin
      state_d = FETCH;
    end

    rd_d      = rd_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    pc_mem_d  = pc_mem_q;
    ins_mem_d = ins_mem_q;
    if (Redirect) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        pc_mem_d[wr_q]  = PCResult;
        ins_mem_d[wr_q] = MemData;
        wr_d            = ptr_inc(wr_q);
      end
      if (pop) rd_d = ptr_inc(rd_q);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= FETCH;
      hold_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]  <= '0;
        ins_mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
      pc_mem_q  <= pc_mem_d;
      ins_mem_q <= ins_mem_d;
    end
  end

  // Reset gates the combinational outputs so a pending request drops immediately.
  always_comb begin
    if (!Reset)        Address = RESET_ADDR;
    else if (Redirect) Address = RedirectTarget;
    else if (push)     Address = 32'(PCResult + 32'd4);
    else               Address = PCResult;
    MemReq      = Reset && req;
    MemAddr     = !Reset ? '0 : (in_fetch ? PCResult : hold_q);
    InstrValid  = valid;
    Instruction = valid ? ins_mem_q[rd_q] : '0;
    InstrPC     = valid ? pc_mem_q[rd_q]  : '0;
  end

`ifdef FETCH_SEQ_PERF_EN
  logic        discard;
  logic [31:0] fetch_cnt_q, fetch_cnt_d, squash_cnt_q, squash_cnt_d;

  always_comb begin
    discard      = ack && (!in_fetch || Redirect);
    fetch_cnt_d  = fetch_cnt_q;
    squash_cnt_d = squash_cnt_q;
    if (push && fetch_cnt_q != '1)     fetch_cnt_d  = fetch_cnt_q + 32'd1;
    if (discard && squash_cnt_q != '1) squash_cnt_d = squash_cnt_q + 32'd1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fetch_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign FetchCount  = fetch_cnt_q;
  assign SquashCount = squash_cnt_q;
`else
  assign FetchCount  = '0;
  assign SquashCount = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: ProgramCounter model, variable-latency memory, IF/ID consumer.
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] PCResult;
  logic [31:0] Address;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck = 1'b0;
  logic [31:0] MemData = '0;
  logic        InstrValid;
  logic [31:0] Instruction;
  logic [31:0] InstrPC;
  logic        InstrReady = 1'b0;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectTarget = '0;
  logic [31:0] FetchCount;
  logic [31:0] SquashCount;

  fetch_sequencer #(.RESET_ADDR(RESET_ADDR), .DEPTH(2)) dut (
    .Clk(Clk), .Reset(Reset), .PCResult(PCResult), .Address(Address),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck), .MemData(MemData),
    .InstrValid(InstrValid), .Instruction(Instruction), .InstrPC(InstrPC),
    .InstrReady(InstrReady), .Redirect(Redirect), .RedirectTarget(RedirectTarget),
    .FetchCount(FetchCount), .SquashCount(SquashCount)
  );

  always #5 Clk = ~Clk;

  logic [31:0] pc;
  always @(posedge Clk or negedge Reset)
    if (!Reset) pc <= RESET_ADDR;
    else        pc <= Address;
  assign PCResult = pc;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned lat      = 0;
  int unsigned wait_cnt = 0;
  logic [31:0] req_addr = '0;
  logic        squash_m = 1'b0;
  logic        ready_en = 1'b0;
  logic        redir    = 1'b0;
  logic [31:0] redir_tgt = '0;
  int unsigned exp_fetch  = 0;
  int unsigned exp_squash = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic chk_counters(input string tag);
`ifdef FETCH_SEQ_PERF_EN
    chk({tag, "_fetch_cnt"}, FetchCount, exp_fetch);
    chk({tag, "_squash_cnt"}, SquashCount, exp_squash);
`else
    chk({tag, "_fetch_cnt"}, FetchCount, 32'd0);
    chk({tag, "_squash_cnt"}, SquashCount, 32'd0);
`endif
  endtask

  task automatic apply_reset();
    Reset = 1'b0; MemAck = 1'b0; MemData = '0; Redirect = 1'b0;
    redir = 1'b0; sb.delete(); squash_m = 1'b0; wait_cnt = 0;
    exp_fetch = 0; exp_squash = 0;
    #1;
    chk("rst_memreq", 32'(MemReq), 32'd0);
    chk("rst_address", Address, RESET_ADDR);
    chk("rst_memaddr", MemAddr, 32'd0);
    chk("rst_valid", 32'(InstrValid), 32'd0);
    chk("rst_instr", Instruction, 32'd0);
    chk("rst_instr_pc", InstrPC, 32'd0);
    chk("rst_fetch_cnt", FetchCount, 32'd0);
    chk("rst_squash_cnt", SquashCount, 32'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
  endtask

  // One clock cycle: drive at the falling edge, check and model, then cross the rising edge.
  task automatic step();
    logic [31:0] exp_addr;
    logic        acked;
    exp_t        e;
    InstrReady     = ready_en;
    Redirect       = redir;
    RedirectTarget = redir_tgt;
    acked   = MemReq && (wait_cnt == lat);
    MemAck  = acked;
    MemData = acked ? mem_word(MemAddr) : '0;
    #1;
    if (MemReq && wait_cnt != 0) chk("memaddr_hold", MemAddr, req_addr);
    if (redir)                      exp_addr = redir_tgt;
    else if (acked && !squash_m)    exp_addr = pc + 32'd4;
    else                            exp_addr = pc;
    chk("address", Address, exp_addr);
    chk("valid", 32'(InstrValid), 32'(sb.size() != 0));
    if (!InstrValid) begin
      chk("instr_empty", Instruction, 32'd0);
      chk("instr_pc_empty", InstrPC, 32'd0);
    end
    if (InstrValid && InstrReady && sb.size() != 0) begin
      e = sb.pop_front();
      chk("instr_pc", InstrPC, e.pc);
      chk("instr", Instruction, e.instr);
    end
    if (acked) begin
      if (squash_m || redir) exp_squash++;
      else begin
        sb.push_back({pc, mem_word(pc)});
        exp_fetch++;
      end
    end
    if (redir) sb.delete();
    if (squash_m) begin
      if (acked) squash_m = 1'b0;
    end else if (redir && MemReq && !acked) begin
      squash_m = 1'b1;
    end
    if (MemReq && !acked) begin
      if (wait_cnt == 0) req_addr = MemAddr;
      wait_cnt++;
    end else begin
      wait_cnt = 0;
    end
    @(posedge Clk);
    #1;
    MemAck = 1'b0; MemData = '0; Redirect = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // zero-wait streaming
    apply_reset();
    lat = 0; ready_en = 1'b1;
    @(negedge Clk);
    for (int i = 0; i < 4; i++) begin
      chk("t1_memreq", 32'(MemReq), 32'd1);
      chk("t1_memaddr", MemAddr, 32'(i * 4));
      if (i > 0) chk("t1_instr_pc", InstrPC, 32'((i - 1) * 4));
      step();
    end
    repeat (2) step();
    chk_counters("t1");

    // back-pressure fills the FIFO and holds the PC
    apply_reset();
    lat = 0; ready_en = 1'b0;
    @(negedge Clk);
    repeat (2) step();
    chk("t2_memreq_full", 32'(MemReq), 32'd0);
    chk("t2_pc_hold", PCResult, 32'd8);
    step();
    chk("t2_pc_still", PCResult, 32'd8);
    ready_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (MemReq) break;
      step();
    end
    chk("t2_resume_req", 32'(MemReq), 32'd1);
    chk("t2_resume_addr", MemAddr, 32'd8);
    repeat (3) step();
    chk_counters("t2");

    // redirect during a slow fetch squashes it
    apply_reset();
    lat = 3; ready_en = 1'b1;
    @(negedge Clk);
    for (int k = 0; k < 20; k++) begin
      if (MemReq && MemAddr == 32'h8) break;
      step();
    end
    chk("t3_reach8", MemAddr, 32'h8);
    step();
    redir = 1'b1; redir_tgt = 32'h100;
    step();
    redir = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (MemAddr == 32'h100) break;
      chk("t3_hold_addr", MemAddr, 32'h8);
      chk("t3_hold_req", 32'(MemReq), 32'd1);
      step();
    end
    chk("t3_target", MemAddr, 32'h100);
    chk("t3_empty", 32'(InstrValid), 32'd0);
    chk_counters("t3");
    repeat (6) step();

    // redirect coincident with ack
    apply_reset();
    lat = 0; ready_en = 1'b1;
    @(negedge Clk);
    repeat (2) step();
    redir = 1'b1; redir_tgt = 32'h40;
    step();
    redir = 1'b0;
    chk("t4_memreq", 32'(MemReq), 32'd1);
    chk("t4_memaddr", MemAddr, 32'h40);
    chk_counters("t4");
    repeat (2) step();

    // asynchronous reset mid-operation with a full FIFO
    lat = 0; ready_en = 1'b0;
    repeat (2) step();
    chk("t5_full_valid", 32'(InstrValid), 32'd1);
    #2;
    apply_reset();

    // PC wrap at the top of the address space
    lat = 0; ready_en = 1'b1;
    @(negedge Clk);
    redir = 1'b1; redir_tgt = 32'hFFFF_FFFC;
    step();
    redir = 1'b0;
    chk("t6_memaddr_top", MemAddr, 32'hFFFF_FFFC);
    step();
    chk("t6_pc_wrap", PCResult, 32'd0);
    chk("t6_memaddr_wrap", MemAddr, 32'd0);
    repeat (3) step();
    chk_counters("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch sequencer that closes the loop around the ProgramCounter register: it consumes `PCResult`, fetches instructions from a variable-latency instruction memory over a req/ack handshake, and drives the next-PC `Address` back into the ProgramCounter. Fetched instructions and their PCs are buffered in a small FIFO and handed to the IF/ID stage over a valid/ready handshake. Branch/jump redirects from EX flush the buffer and squash any in-flight fetch.

## Interface
- `RESET_ADDR`, default 32'h0000_0000: value driven on `Address` while reset is asserted.
- `DEPTH`, default 2: instruction FIFO entries, 2..4.
- `Clk`  input  1  rising-edge clock.
- `Reset`  input  1  asynchronous, active-low reset.
- `PCResult`  input  32  current PC from the ProgramCounter.
- `Address`  output  32  next PC to the ProgramCounter (combinational).
- `MemReq`  output  1  instruction memory request.
- `MemAddr`  output  32  fetch address, stable while `MemReq`=1 until ack.
- `MemAck`  input  1  one-cycle pulse; `MemData` valid this cycle.
- `MemData`  input  32  fetched instruction word.
- `InstrValid`  output  1  FIFO head valid.
- `Instruction`  output  32  FIFO head instruction, 0 when empty.
- `InstrPC`  output  32  FIFO head PC, 0 when empty.
- `InstrReady`  input  1  IF/ID accepts head.
- `Redirect`  input  1  one-cycle redirect request from EX.
- `RedirectTarget`  input  32  redirect PC.
- `FetchCount`  output  32  accepted-fetch counter (see Configuration).
- `SquashCount`  output  32  discarded-fetch counter (see Configuration).

## Operation
- FSM states: FETCH, SQUASH. Reset state is FETCH.
- `room` = FIFO count < `DEPTH`, taken from registered count. It does not depend on `InstrReady`.
- FETCH:
  - `MemReq` = `room`; `MemAddr` = `PCResult`.
  - On `MemAck` with no `Redirect`: push {`PCResult`, `MemData`}; `Address` = `PCResult`+4.
  - Otherwise `Address` = `PCResult`, so the PC holds.
- `Redirect` takes priority over everything else:
  - `Address` = `RedirectTarget`; FIFO flushed at the next edge.
  - A pop completing in the same cycle still counts as completed.
  - In FETCH with `MemReq`=1 and no `MemAck`: capture `PCResult` into the hold register and go to SQUASH.
  - In FETCH with `MemAck` in the same cycle: data discarded, stay in FETCH.
- SQUASH:
  - `MemReq`=1; `MemAddr` = hold register; `Address` = `PCResult`, or `RedirectTarget` if `Redirect`.
  - On `MemAck`: discard data, go to FETCH.
  - A further `Redirect` in SQUASH stays in SQUASH.
- FIFO:
  - Pop when `InstrValid` && `InstrReady`.
  - Push and pop in the same cycle are legal whenever `room`.
  - Never overflows, because `MemReq` requires `room`.
- PC arithmetic is 32-bit unsigned and wraps from 32'hFFFF_FFFC to 0. No alignment checking.

## Timing
- Reset (`Reset`=0, asynchronous):
  - `Address`=`RESET_ADDR`; `MemReq`=0; `MemAddr`=0.
  - `InstrValid`=0; `Instruction`=0; `InstrPC`=0.
  - FIFO empty; hold register 0; counters 0; FSM = FETCH.
  - Reset mid-fetch abandons the request. Memory must drop it.
- `MemReq` can be acknowledged in the same cycle it rises (zero-wait). The resulting throughput is 1 instruction/cycle.
- Fetch-to-output latency: the instruction acked at edge N is on `Instruction` after edge N, with `InstrValid`=1 in cycle N+1.
- Redirect at cycle N: the ProgramCounter loads the target at edge N. The first target fetch is presented in cycle N+1 if in FETCH, or the cycle after the squashed ack.
- `Address`, `MemReq`, and `MemAddr` (in FETCH) are combinational from state, `PCResult`, `MemAck`, and `Redirect`. There is no path from `InstrReady`.

## Configuration
- `FETCH_SEQ_PERF_EN` defined: enables the counters.
  - `FetchCount` increments on every FIFO push.
  - `SquashCount` increments on every discarded ack (SQUASH ack, or ack coincident with `Redirect`).
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Not defined: both outputs tied to 0 and no counter flops are generated.

## Test plan
- Reset release, zero-wait memory, `InstrReady`=1 -> `MemAddr` 0,4,8 on consecutive cycles; `InstrPC` 0,4,8 one cycle later; `Address` runs 4,8,12.
- `InstrReady`=0 from reset, zero-wait memory, `DEPTH`=2 -> two pushes (PC 0,4), then `MemReq`=0 and `Address`=`PCResult`=8 holding; raising `InstrReady` resumes at 8.
- Ack delay 3 cycles; `Redirect` to 32'h100 one cycle after `MemReq` at 32'h8 -> SQUASH, `MemAddr` held 32'h8 until ack, data discarded, next `MemAddr`=32'h100, FIFO empty.
- `Redirect` to 32'h40 coincident with `MemAck` -> no push, stay in FETCH, next cycle `MemAddr`=32'h40; with macro, `SquashCount`=1.
- `Reset` asserted mid-operation with FIFO holding 2 entries -> immediately `InstrValid`=0, `MemReq`=0, `Address`=`RESET_ADDR`.
- PC at 32'hFFFF_FFFC fetched -> `Address`=0 and the next fetch is at 0.
